// File: rtl/mapu_nxn_if.sv
// rtl/mapu_nxn_if.sv - row-stream operand/result bundle for mapu_nxn
interface mapu_nxn_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 3
);
    logic [1:0]              i_op;
    logic                    i_vld;
    logic                    o_rdy;
    logic [N*DATA_WIDTH-1:0] i_row;
    logic                    o_vld;
    logic                    i_rdy;
    logic [N*DATA_WIDTH-1:0] o_row;
    logic                    o_last;
    logic                    o_of;

    modport slave (
        input  i_op, i_vld, i_row, i_rdy,
        output o_rdy, o_vld, o_row, o_last, o_of
    );

    modport master (
        output i_op, i_vld, i_row, i_rdy,
        input  o_rdy, o_vld, o_row, o_last, o_of
    );
endinterface

// File: rtl/mapu_nxn.sv
// rtl/mapu_nxn.sv - NxN matrix add/sub/mult/transpose unit with row streaming
module mapu_nxn #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 3,
    parameter int SATURATE   = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clr,
    mapu_nxn_if.slave   io
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(N);
    localparam int WW = 2 * DW + 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_TRN = 2'd3;

    typedef logic [N-1:0][DW-1:0]        row_t;
    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, UNLOAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic          of_q, of_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    mat_t          a_q, a_d, b_q, b_d, c_q, c_d;
    row_t          res_row;
    logic          res_of;
    logic          beat;

    function automatic logic [WW-1:0] ext(input logic [DW-1:0] x);
        return {{(WW - DW){1'b0}}, x};
    endfunction

    // Result row cnt_q, computed at full width so carry/borrow/product overflow is exact
    always_comb begin
        logic [WW-1:0] acc;
        logic          elem_of;
        res_row = '0;
        res_of  = 1'b0;
        for (int j = 0; j < N; j++) begin
            acc     = '0;
            elem_of = 1'b0;
            case (op_q)
                OP_ADD: begin
                    acc     = ext(a_q[cnt_q][j]) + ext(b_q[cnt_q][j]);
                    elem_of = |acc[WW-1:DW];
                end
                OP_SUB: begin
                    acc     = ext(a_q[cnt_q][j]) - ext(b_q[cnt_q][j]);
                    elem_of = a_q[cnt_q][j] < b_q[cnt_q][j];
                end
                OP_MUL: begin
                    for (int k = 0; k < N; k++) begin
                        acc = acc + ext(a_q[cnt_q][k]) * ext(b_q[k][j]);
                    end
                    elem_of = |acc[WW-1:DW];
                end
                default: acc = ext(a_q[j][cnt_q]);
            endcase
            if (elem_of && (SATURATE != 0)) begin
                res_row[j] = (op_q == OP_SUB) ? '0 : '1;
            end else begin
                res_row[j] = acc[DW-1:0];
            end
            res_of = res_of | elem_of;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        of_d    = of_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        beat    = io.i_vld && rdy_q;
        case (state_q)
            LOAD_A: begin
                rdy_d = 1'b1;
                if (beat) begin
                    a_d[cnt_q] = io.i_row;
                    if (cnt_q == '0) begin
                        op_d = io.i_op;
                        of_d = 1'b0;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (op_q == OP_TRN) begin
                            state_d = COMPUTE;
                            rdy_d   = 1'b0;
                        end else begin
                            state_d = LOAD_B;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    b_d[cnt_q] = io.i_row;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = COMPUTE;
                        rdy_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                c_d[cnt_q] = res_row;
                if (res_of) begin
                    of_d = 1'b1;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = UNLOAD;
                    vld_d   = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (io.i_rdy) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_A;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        rdy_d   = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        last_d = (cnt_q + 1'b1) == LAST;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
        // Abort wins over any beat or row advance in the same cycle
        if (i_clr) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            of_d    = 1'b0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            rdy_d   = 1'b1;
            a_d     = a_q;
            b_d     = b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            of_q    <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            of_q    <= of_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
    end

    assign io.o_rdy  = rdy_q;
    assign io.o_vld  = vld_q;
    assign io.o_last = last_q;
    assign io.o_of   = of_q;
    assign io.o_row  = vld_q ? c_q[cnt_q] : '0;
endmodule

// File: tb/tb_mapu_nxn.sv
// tb/tb_mapu_nxn.sv - scoreboard bench for mapu_nxn (3x3x32 wrap and 2x2x8 saturating)
module tb_mapu_nxn;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        drv_clr = 1'b0;
    logic        drv_vld = 1'b0;
    logic        drv_rdy = 1'b1;
    logic [1:0]  drv_op = 2'd0;
    logic [95:0] drv_row = '0;
    logic        sel = 1'b0;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [95:0] row;
        logic        last;
        logic        of;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ma [4][4];
    logic [31:0] mb [4][4];

    mapu_nxn_if #(.DATA_WIDTH(32), .N(3)) if0 ();
    mapu_nxn_if #(.DATA_WIDTH(8),  .N(2)) if1 ();

    mapu_nxn #(.DATA_WIDTH(32), .N(3), .SATURATE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .i_clr(drv_clr), .io(if0)
    );
    mapu_nxn #(.DATA_WIDTH(8), .N(2), .SATURATE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .i_clr(drv_clr), .io(if1)
    );

    always #5 clk = ~clk;

    assign if0.i_vld = drv_vld & ~sel;
    assign if1.i_vld = drv_vld & sel;
    assign if0.i_row = drv_row;
    assign if1.i_row = drv_row[15:0];
    assign if0.i_op  = drv_op;
    assign if1.i_op  = drv_op;
    assign if0.i_rdy = drv_rdy;
    assign if1.i_rdy = drv_rdy;

    logic        obs_rdy, obs_vld, obs_last, obs_of;
    logic [95:0] obs_row;
    assign obs_rdy  = sel ? if1.o_rdy  : if0.o_rdy;
    assign obs_vld  = sel ? if1.o_vld  : if0.o_vld;
    assign obs_last = sel ? if1.o_last : if0.o_last;
    assign obs_of   = sel ? if1.o_of   : if0.o_of;
    assign obs_row  = sel ? {80'd0, if1.o_row} : if0.o_row;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes the N expected result rows of the matrix in ma/mb
    task automatic model_push(input int n, input int dw, input int sat, input int op);
        logic [65:0] mask, full, res;
        logic        ov, mof;
        logic [31:0] mc [4][4];
        logic [95:0] row;
        mask = (66'd1 << dw) - 66'd1;
        mof  = 1'b0;
        for (int r = 0; r < n; r++) begin
            for (int j = 0; j < n; j++) begin
                full = '0;
                case (op)
                    0: begin
                        full = {34'd0, ma[r][j]} + {34'd0, mb[r][j]};
                        ov   = full > mask;
                    end
                    1: begin
                        for (int k = 0; k < n; k++) full = full + {34'd0, ma[r][k]} * {34'd0, mb[k][j]};
                        ov = full > mask;
                    end
                    2: begin
                        full = {34'd0, ma[r][j]} - {34'd0, mb[r][j]};
                        ov   = ma[r][j] < mb[r][j];
                    end
                    default: begin
                        full = {34'd0, ma[j][r]};
                        ov   = 1'b0;
                    end
                endcase
                res = (ov && sat != 0) ? ((op == 2) ? 66'd0 : mask) : (full & mask);
                mc[r][j] = res[31:0];
                mof = mof | ov;
            end
        end
        for (int r = 0; r < n; r++) begin
            row = '0;
            for (int j = 0; j < n; j++) row = row | ({64'd0, mc[r][j]} << (j * dw));
            exp_q.push_back('{row, (r == n - 1), mof});
        end
    endtask

    function automatic logic [95:0] pack_row(input int which, input int r, input int n, input int dw);
        logic [95:0] p;
        p = '0;
        for (int j = 0; j < n; j++) p = p | ({64'd0, (which != 0) ? mb[r][j] : ma[r][j]} << (j * dw));
        return p;
    endfunction

    task automatic send_row(input logic [95:0] row, input logic [1:0] op);
        int t;
        t = 0;
        while (obs_rdy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("o_rdy_timeout", {95'd0, obs_rdy}, 96'd1);
        drv_row = row;
        drv_op  = op;
        drv_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_vld = 1'b0;
        drv_op  = 2'($urandom_range(0, 3));
    endtask

    // Later beats carry a random i_op to show only the first A beat latches it
    task automatic load(input int n, input int dw, input int sat, input int op);
        model_push(n, dw, sat, op);
        for (int r = 0; r < n; r++) send_row(pack_row(0, r, n, dw), (r == 0) ? 2'(op) : 2'($urandom_range(0, 3)));
        if (op != 3) begin
            for (int r = 0; r < n; r++) send_row(pack_row(1, r, n, dw), 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic wait_vld(output int t);
        t = 0;
        while (obs_vld !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic drain(input int n);
        exp_t e;
        int   t;
        for (int r = 0; r < n; r++) begin
            wait_vld(t);
            chk("o_vld", {95'd0, obs_vld}, 96'd1);
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 96'd0, 96'd1);
                e = '{96'd0, 1'b0, 1'b0};
            end else begin
                e = exp_q.pop_front();
            end
            chk("o_row", obs_row, e.row);
            chk("o_last", {95'd0, obs_last}, {95'd0, e.last});
            chk("o_of", {95'd0, obs_of}, {95'd0, e.of});
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic fill(input int n, input int a_base, input int a_step, input int b_val);
        for (int r = 0; r < n; r++)
            for (int j = 0; j < n; j++) begin
                ma[r][j] = 32'(a_base + a_step * (r * n + j));
                mb[r][j] = 32'(b_val);
            end
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_o_rdy", {95'd0, obs_rdy}, 96'd0);
        chk("rst_o_vld", {95'd0, obs_vld}, 96'd0);
        chk("rst_o_last", {95'd0, obs_last}, 96'd0);
        chk("rst_o_of", {95'd0, obs_of}, 96'd0);
        chk("rst_o_row", obs_row, 96'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_o_rdy", {95'd0, obs_rdy}, 96'd1);

        // add, with N-cycle compute latency
        fill(3, 1, 1, 10);
        load(3, 32, 0, 0);
        chk("compute_o_rdy", {95'd0, obs_rdy}, 96'd0);
        wait_vld(lat);
        chk("latency", 96'(lat), 96'd3);
        drain(3);

        // mult by identity, by all-2, and by random operands
        fill(3, 1, 1, 0);
        for (int i = 0; i < 3; i++) mb[i][i] = 32'd1;
        load(3, 32, 0, 1);
        drain(3);
        fill(3, 1, 1, 2);
        load(3, 32, 0, 1);
        drain(3);
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++) begin
                ma[r][j] = $urandom;
                mb[r][j] = $urandom;
            end
        load(3, 32, 0, 1);
        drain(3);

        // wrapping overflow: add carry, sub borrow, mult, then clean matrix
        fill(3, 32'hFFFF_FFFF, 0, 2);
        load(3, 32, 0, 0);
        drain(3);
        fill(3, 5, 0, 7);
        load(3, 32, 0, 2);
        drain(3);
        fill(3, 32'h0001_0000, 0, 32'h0001_0000);
        load(3, 32, 0, 1);
        drain(3);
        fill(3, 100, 3, 40);
        load(3, 32, 0, 2);
        drain(3);

        // transpose skips the B phase
        fill(3, 0, 1, 0);
        load(3, 32, 0, 3);
        chk("trn_o_rdy", {95'd0, obs_rdy}, 96'd0);
        drain(3);

        // backpressure on row 1
        fill(3, 1, 1, 10);
        load(3, 32, 0, 0);
        drain(1);
        drv_rdy = 1'b0;
        repeat (5) begin
            chk("bp_o_vld", {95'd0, obs_vld}, 96'd1);
            chk("bp_o_row", obs_row, exp_q[0].row);
            chk("bp_o_last", {95'd0, obs_last}, 96'd0);
            @(posedge clk);
            @(negedge clk);
        end
        drv_rdy = 1'b1;
        drain(2);
        chk("bp_done_o_rdy", {95'd0, obs_rdy}, 96'd1);
        chk("bp_done_o_vld", {95'd0, obs_vld}, 96'd0);

        // reset during UNLOAD row 1 of an overflowing matrix
        fill(3, 32'hFFFF_FFFF, 0, 1);
        load(3, 32, 0, 0);
        drain(1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_o_vld", {95'd0, obs_vld}, 96'd0);
        chk("rstmid_o_of", {95'd0, obs_of}, 96'd0);
        chk("rstmid_o_rdy", {95'd0, obs_rdy}, 96'd0);
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        fill(3, 2, 2, 3);
        load(3, 32, 0, 0);
        drain(3);

        // i_clr on LOAD_B beat 1, then a fresh matrix
        fill(3, 9, 1, 4);
        for (int r = 0; r < 3; r++) send_row(pack_row(0, r, 3, 32), 2'd1);
        send_row(pack_row(1, 0, 3, 32), 2'd0);
        drv_row = pack_row(1, 1, 3, 32);
        drv_vld = 1'b1;
        drv_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_vld = 1'b0;
        drv_clr = 1'b0;
        chk("clr_o_vld", {95'd0, obs_vld}, 96'd0);
        chk("clr_o_of", {95'd0, obs_of}, 96'd0);
        chk("clr_o_rdy", {95'd0, obs_rdy}, 96'd1);
        load(3, 32, 0, 1);
        drain(3);

        // 2x2x8 saturating instance
        sel = 1'b1;
        @(negedge clk);
        fill(2, 200, 0, 100);
        load(2, 8, 1, 0);
        drain(2);
        fill(2, 5, 0, 7);
        load(2, 8, 1, 2);
        drain(2);
        fill(2, 16, 0, 16);
        load(2, 8, 1, 1);
        drain(2);
        fill(2, 1, 1, 2);
        load(2, 8, 1, 0);
        drain(2);
        fill(2, 10, 1, 0);
        load(2, 8, 1, 3);
        drain(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
